// File: rtl/cp0_intc.sv
// Coprocessor-0 exception/interrupt controller: Status/Cause/EPC, fixed-priority arbitration,
// flat or vectored handlers. Define CP0_IRQ_SYNC_EN to add 2-flop synchronisers on irq_i.
module cp0_intc #(
    parameter int unsigned N_IRQ       = 6,
    parameter int unsigned N_TRAP      = 2,
    parameter int unsigned VEC_SPACING = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [4:0]        addr_i,
    input  logic [31:0]       wd_i,
    output logic [31:0]       rd_o,
    input  logic [N_IRQ-1:0]  irq_i,
    input  logic [N_TRAP-1:0] trap_i,
    input  logic [31:0]       pcp4_i,
    input  logic              eret_i,
    output logic              take_o,
    output logic [31:0]       vector_o,
    output logic [31:0]       epc_o,
    output logic              exl_o
);
    localparam int unsigned NS = N_IRQ + N_TRAP;
    localparam logic [3:0] NTrapW = 4'(N_TRAP);

    typedef enum logic [1:0] {StIdle, StTake, StHandler, StReturn} state_e;

    state_e        state_q, state_d;
    logic          ie_q, ie_d, exl_q, exl_d, iv_q, iv_d;
    logic [NS-1:0] mask_q, mask_d, pend_q, pend_d;
    logic [4:0]    exc_q, exc_d;
    logic [31:0]   epc_q, epc_d;
    logic [3:0]    win_q, win_d;

    logic [N_IRQ-1:0] irq_s;
    logic [NS-1:0]    src, elig;
    logic [3:0]       win_c;
    logic             wr_status, wr_cause, wr_epc;
    logic [31:0]      status_v, cause_v, win_ext;

`ifdef CP0_IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    assign src       = {irq_s, trap_i};
    assign elig      = pend_q & mask_q;
    assign wr_status = we_i && (addr_i == 5'd12);
    assign wr_cause  = we_i && (addr_i == 5'd13);
    assign wr_epc    = we_i && (addr_i == 5'd14);

    // Lowest eligible index wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_c = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (elig[i]) win_c = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        exl_d   = exl_q;
        iv_d    = iv_q;
        mask_d  = mask_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        win_d   = win_q;
        // Set beats a simultaneous W1C on the same bit.
        pend_d  = (pend_q & ~(wr_cause ? wd_i[8 +: NS] : '0)) | (src & mask_q);
        if (wr_status) begin
            ie_d   = wd_i[0];
            mask_d = wd_i[8 +: NS];
        end
        if (wr_cause) iv_d  = wd_i[23];
        if (wr_epc)   epc_d = wd_i;
        case (state_q)
            StIdle: begin
                if (ie_q && !exl_q && (|elig)) begin
                    state_d = StTake;
                    win_d   = win_c;
                end
            end
            StTake: begin
                epc_d   = pcp4_i;
                exl_d   = 1'b1;
                exc_d   = (win_q < NTrapW) ? 5'd13 : 5'd0;
                state_d = StHandler;
            end
            StHandler: if (eret_i) state_d = StReturn;
            StReturn: begin
                exl_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            iv_q    <= 1'b0;
            mask_q  <= '0;
            pend_q  <= '0;
            exc_q   <= 5'd10;
            epc_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            iv_q    <= iv_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        status_v           = '0;
        status_v[0]        = ie_q;
        status_v[1]        = exl_q;
        status_v[8 +: NS]  = mask_q;
        cause_v            = '0;
        cause_v[8 +: NS]   = pend_q;
        cause_v[6:2]       = exc_q;
        cause_v[23]        = iv_q;
        case (addr_i)
            5'd12:   rd_o = status_v;
            5'd13:   rd_o = cause_v;
            5'd14:   rd_o = epc_q;
            default: rd_o = '0;
        endcase
    end

    assign win_ext  = {28'd0, win_q};
    assign vector_o = iv_q ? (32'h200 + 32'(VEC_SPACING) * win_ext) : 32'h180;
    assign take_o   = (state_q == StTake);
    assign exl_o    = exl_q;
    assign epc_o    = epc_q;
endmodule
